turn_checker: RTL and testbench

Player-turn controller for the Genius game, sitting directly downstream of the turn timer. It drives the timer's reset/enable, walks the stored colour sequence via `SEQ_ADDR`, and checks each button press against `SEQ_DATA`. It declares `WIN` when the whole round is entered correctly, or `LOSE` on a wrong colour or a timer expiry (`END_TIME`).

---
 rtl/turn_checker.sv | 165 ++++++++++++++++
 tb/tb_turn_checker.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_checker.sv
// Player-turn controller for the Genius game: drives the turn timer, walks the stored
// sequence and judges each press. Optional debounce: define TURN_CHECKER_DEBOUNCE_EN.
module turn_checker #(
    parameter int DEB_CYCLES = 1000
) (
    input  logic       CLK,
    input  logic       R,
    input  logic       START,
    input  logic [3:0] ROUND,
    input  logic [3:0] BTN,
    input  logic [1:0] SEQ_DATA,
    input  logic       END_TIME,
    output logic [3:0] SEQ_ADDR,
    output logic [3:0] SCORE,
    output logic       TIMER_R,
    output logic       TIMER_E,
    output logic       BUSY,
    output logic       WIN,
    output logic       LOSE
);

    if (DEB_CYCLES < 1 || DEB_CYCLES > 65535) begin : g_bad_deb
        $error("turn_checker: DEB_CYCLES out of range 1..65535");
    end

    typedef enum logic [2:0] {
        IDLE, ARM, WAIT_BTN, CHECK, RESTART, RELEASE, WON, LOST
    } state_t;

    state_t     state;
    logic [4:0] round_len;
    logic [3:0] cap;
    logic [1:0] cap_code;
    logic       cap_multi;
    logic       end_prev;
    logic       end_rise;
    logic       press_ok;
    logic       release_ok;

    assign end_rise = END_TIME & ~end_prev;

    always_comb begin
        cap_code = 2'd0;
        case (cap)
            4'b0010: cap_code = 2'd1;
            4'b0100: cap_code = 2'd2;
            4'b1000: cap_code = 2'd3;
            default: cap_code = 2'd0;
        endcase
    end

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign cap_multi = |(cap & (cap - 4'd1));

`ifdef TURN_CHECKER_DEBOUNCE_EN
    localparam logic [15:0] DEB_N = 16'(DEB_CYCLES);

    logic [15:0] deb_cnt;
    logic [15:0] cnt_now;
    logic [3:0]  deb_last;
    logic        deb_win;

    assign deb_win = (state == WAIT_BTN) || (state == RELEASE);

    // deb_cnt == 0 means "no history": the run length restarts at 1 on entry or change.
    always_comb begin
        cnt_now = 16'd1;
        if (deb_cnt != 16'd0 && BTN == deb_last)
            cnt_now = (deb_cnt == 16'hffff) ? deb_cnt : deb_cnt + 16'd1;
    end

    assign press_ok   = (BTN != 4'd0) && (cnt_now >= DEB_N);
    assign release_ok = (BTN == 4'd0) && (cnt_now >= DEB_N);

    always_ff @(posedge CLK) begin
        if (!R) begin
            deb_cnt  <= 16'd0;
            deb_last <= 4'd0;
        end else if (deb_win) begin
            deb_cnt  <= cnt_now;
            deb_last <= BTN;
        end else begin
            deb_cnt  <= 16'd0;
        end
    end
`else
    logic [3:0] btn_prev;

    assign press_ok   = (btn_prev == 4'd0) && (BTN != 4'd0);
    assign release_ok = (BTN == 4'd0);

    always_ff @(posedge CLK) begin
        if (!R) btn_prev <= 4'd0;
        else    btn_prev <= BTN;
    end
`endif

    always_ff @(posedge CLK) begin
        if (!R) begin
            state     <= IDLE;
            SEQ_ADDR  <= 4'd0;
            SCORE     <= 4'd0;
            WIN       <= 1'b0;
            LOSE      <= 1'b0;
            round_len <= 5'd0;
            cap       <= 4'd0;
            end_prev  <= 1'b0;
        end else begin
            end_prev <= END_TIME;
            case (state)
                IDLE, WON, LOST: begin
                    if (START) begin
                        round_len <= (ROUND == 4'd0) ? 5'd16 : {1'b0, ROUND};
                        SEQ_ADDR  <= 4'd0;
                        SCORE     <= 4'd0;
                        WIN       <= 1'b0;
                        LOSE      <= 1'b0;
                        state     <= ARM;
                    end
                end
                ARM: state <= WAIT_BTN;
                WAIT_BTN: begin
                    if (end_rise) begin
                        LOSE  <= 1'b1;
                        state <= LOST;
                    end else if (press_ok) begin
                        cap   <= BTN;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (cap_multi || cap_code != SEQ_DATA) begin
                        LOSE  <= 1'b1;
                        state <= LOST;
                    end else begin
                        // SCORE wraps to 0 only on the 16th entry of a 16-entry round.
                        SCORE <= SCORE + 4'd1;
                        if ({1'b0, SCORE} + 5'd1 == round_len) begin
                            WIN   <= 1'b1;
                            state <= WON;
                        end else begin
                            SEQ_ADDR <= SEQ_ADDR + 4'd1;
                            state    <= RESTART;
                        end
                    end
                end
                RESTART: state <= RELEASE;
                RELEASE: begin
                    if (end_rise) begin
                        LOSE  <= 1'b1;
                        state <= LOST;
                    end else if (release_ok) begin
                        state <= WAIT_BTN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign TIMER_R = state inside {IDLE, ARM, RESTART, WON, LOST};
    assign TIMER_E = state inside {WAIT_BTN, CHECK, RELEASE};
    assign BUSY    = !(state inside {IDLE, WON, LOST});

endmodule

// File: tb/tb_turn_checker.sv
// Bench for turn_checker: per-cycle vector table, directed corner sequences, and
// randomized games judged by a game-level model (outcome, score, address).
module tb_turn_checker;

    logic       CLK = 1'b0;
    logic       R = 1'b0;
    logic       START = 1'b0;
    logic [3:0] ROUND = 4'd0;
    logic [3:0] BTN = 4'd0;
    logic       END_TIME = 1'b0;
    logic [1:0] SEQ_DATA;
    logic [3:0] SEQ_ADDR, SCORE;
    logic       TIMER_R, TIMER_E, BUSY, WIN, LOSE;

    logic [1:0] mem [16];
    int total = 0;
    int bad = 0;

    assign SEQ_DATA = mem[SEQ_ADDR];

    always #5 CLK = ~CLK;

    turn_checker #(.DEB_CYCLES(1000)) dut (
        .CLK(CLK), .R(R), .START(START), .ROUND(ROUND), .BTN(BTN),
        .SEQ_DATA(SEQ_DATA), .END_TIME(END_TIME), .SEQ_ADDR(SEQ_ADDR),
        .SCORE(SCORE), .TIMER_R(TIMER_R), .TIMER_E(TIMER_E), .BUSY(BUSY),
        .WIN(WIN), .LOSE(LOSE)
    );

    typedef struct {
        logic       start;
        logic [3:0] round;
        logic [3:0] btn;
        logic       tr, te, busy, win, lose;
        logic [3:0] score, addr;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Leaves the DUT in WAIT_BTN with the next press sampled at the coming edge.
    task automatic do_start(input logic [3:0] r);
        START = 1'b1;
        ROUND = r;
        step(1);
        START = 1'b0;
        step(1);
    endtask

    task automatic press(input logic [3:0] b, input int hold, input int gap, input bit pulse);
        BTN = b;
        step(hold);
        BTN = 4'd0;
        if (pulse) begin
            START = 1'b1;
            ROUND = 4'($urandom);
            step(1);
            START = 1'b0;
            step(gap - 1);
        end else begin
            step(gap);
        end
    endtask

    task automatic chk_idle_reset(input string nm);
        chk({nm, ".timer_r"}, TIMER_R, 1);
        chk({nm, ".timer_e"}, TIMER_E, 0);
        chk({nm, ".busy"}, BUSY, 0);
        chk({nm, ".win"}, WIN, 0);
        chk({nm, ".lose"}, LOSE, 0);
        chk({nm, ".addr"}, SEQ_ADDR, 0);
        chk({nm, ".score"}, SCORE, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[14];
        for (int i = 0; i < 16; i++) mem[i] = 2'd0;
        mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;

        //           st rnd btn     tr te bsy win los scr adr
        tv[0]  = '{1, 3, 4'h0,  1, 0, 1, 0, 0, 0, 0};
        tv[1]  = '{0, 3, 4'h0,  0, 1, 1, 0, 0, 0, 0};
        tv[2]  = '{0, 3, 4'h4,  0, 1, 1, 0, 0, 0, 0};
        tv[3]  = '{0, 3, 4'h4,  1, 0, 1, 0, 0, 1, 1};
        tv[4]  = '{0, 3, 4'h4,  0, 1, 1, 0, 0, 1, 1};
        tv[5]  = '{0, 3, 4'h4,  0, 1, 1, 0, 0, 1, 1};
        tv[6]  = '{0, 3, 4'h0,  0, 1, 1, 0, 0, 1, 1};
        tv[7]  = '{0, 3, 4'h1,  0, 1, 1, 0, 0, 1, 1};
        tv[8]  = '{1, 7, 4'h0,  1, 0, 1, 0, 0, 2, 2};
        tv[9]  = '{0, 3, 4'h0,  0, 1, 1, 0, 0, 2, 2};
        tv[10] = '{0, 3, 4'h0,  0, 1, 1, 0, 0, 2, 2};
        tv[11] = '{0, 3, 4'h8,  0, 1, 1, 0, 0, 2, 2};
        tv[12] = '{0, 3, 4'h0,  1, 0, 0, 1, 0, 3, 2};
        tv[13] = '{0, 3, 4'h0,  1, 0, 0, 1, 0, 3, 2};

        @(negedge CLK);
        step(2);
        chk_idle_reset("reset");
        R = 1'b1;
        step(1);
        chk_idle_reset("post_reset");

        for (int i = 0; i < 14; i++) begin
            START = tv[i].start;
            ROUND = tv[i].round;
            BTN   = tv[i].btn;
            step(1);
            chk($sformatf("vec%0d.timer_r", i), TIMER_R, tv[i].tr);
            chk($sformatf("vec%0d.timer_e", i), TIMER_E, tv[i].te);
            chk($sformatf("vec%0d.busy", i), BUSY, tv[i].busy);
            chk($sformatf("vec%0d.win", i), WIN, tv[i].win);
            chk($sformatf("vec%0d.lose", i), LOSE, tv[i].lose);
            chk($sformatf("vec%0d.score", i), SCORE, tv[i].score);
            chk($sformatf("vec%0d.addr", i), SEQ_ADDR, tv[i].addr);
        end
        START = 1'b0;
        BTN = 4'd0;

        // Wrong colour on the second entry.
        mem[0] = 2'd1; mem[1] = 2'd0;
        do_start(4);
        press(4'b0010, 1, 4, 0);
        chk("wrong.score1", SCORE, 1);
        BTN = 4'b0100;
        step(1);
        chk("wrong.lose_early", LOSE, 0);
        step(1);
        chk("wrong.lose", LOSE, 1);
        chk("wrong.score", SCORE, 1);
        BTN = 4'd0;
        step(2);

        // Plain timeout.
        do_start(5);
        step(3);
        chk("tmo.pre", LOSE, 0);
        END_TIME = 1'b1;
        step(1);
        chk("tmo.lose", LOSE, 1);
        chk("tmo.busy", BUSY, 0);
        END_TIME = 1'b0;
        step(2);

        // END_TIME edge during ARM is ignored; then timeout beats a correct press.
        mem[0] = 2'd3;
        START = 1'b1; ROUND = 4'd4;
        step(1);
        START = 1'b0; END_TIME = 1'b1;
        step(1);
        step(2);
        chk("arm_tmo.lose", LOSE, 0);
        chk("arm_tmo.busy", BUSY, 1);
        END_TIME = 1'b0;
        step(1);
        BTN = 4'b1000; END_TIME = 1'b1;
        step(1);
        chk("tmo_press.lose", LOSE, 1);
        BTN = 4'd0; END_TIME = 1'b0;
        step(2);
        chk("tmo_press.score", SCORE, 0);
        chk("tmo_press.win", WIN, 0);

        // Multi-bit press.
        mem[0] = 2'd0;
        do_start(4);
        press(4'b0011, 1, 4, 0);
        chk("multi.lose", LOSE, 1);
        chk("multi.score", SCORE, 0);

        // Held button counts once; then reset mid-turn.
        mem[0] = 2'd2; mem[1] = 2'd1;
        do_start(4);
        BTN = 4'b0100;
        step(20);
        BTN = 4'd0;
        step(4);
        chk("held.score", SCORE, 1);
        chk("held.addr", SEQ_ADDR, 1);
        chk("held.busy", BUSY, 1);
        chk("held.lose", LOSE, 0);
        press(4'b0010, 1, 4, 0);
        chk("held.score2", SCORE, 2);
        R = 1'b0;
        step(2);
        R = 1'b1;
        step(1);
        chk_idle_reset("midturn_reset");

        // 16-entry round with START pulsed mid-turn.
        for (int i = 0; i < 16; i++) mem[i] = 2'($urandom_range(0, 3));
        do_start(0);
        for (int i = 0; i < 16; i++) begin
            press(4'b0001 << mem[i], 1, 4, 0);
            if (i == 7) begin
                START = 1'b1; ROUND = 4'd5;
                step(1);
                START = 1'b0;
                chk("r16.mid_score", SCORE, 8);
                chk("r16.mid_addr", SEQ_ADDR, 8);
                chk("r16.mid_busy", BUSY, 1);
            end
            if (i == 14) chk("r16.win_early", WIN, 0);
        end
        chk("r16.win", WIN, 1);
        chk("r16.lose", LOSE, 0);
        chk("r16.score", SCORE, 0);
        chk("r16.addr", SEQ_ADDR, 15);
        chk("r16.busy", BUSY, 0);

        // Randomized games against a game-level outcome model.
        for (int g = 0; g < 40; g++) begin
            int len, to_idx, exp_score;
            bit exp_win, exp_lose;
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            len = (r == 4'd0) ? 16 : int'(r);
            for (int i = 0; i < 16; i++) mem[i] = 2'($urandom_range(0, 3));
            to_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            exp_score = 0; exp_win = 0; exp_lose = 0;
            do_start(r);
            for (int j = 0; j < len; j++) begin
                int kind, hold, gap;
                bit ok, last, pulse;
                logic [3:0] b;
                if (j == to_idx) begin
                    END_TIME = 1'b1;
                    step(1);
                    END_TIME = 1'b0;
                    step(2);
                    exp_lose = 1;
                    break;
                end
                kind = int'($urandom_range(0, 9));
                if (kind == 0) begin
                    int w;
                    w = (int'(mem[j]) + int'($urandom_range(1, 3))) % 4;
                    b = 4'b0001 << w;
                end else if (kind == 1) begin
                    do b = 4'($urandom_range(3, 15)); while ($countones(b) < 2);
                end else begin
                    b = 4'b0001 << mem[j];
                end
                ok = (kind >= 2);
                last = ok && (j == len - 1);
                pulse = ok && !last && ($urandom_range(0, 4) == 0);
                hold = int'($urandom_range(1, 6));
                gap = int'($urandom_range(4, 7));
                press(b, hold, gap, pulse);
                if (!ok) begin
                    exp_lose = 1;
                    break;
                end
                exp_score++;
                if (last) exp_win = 1;
            end
            step(2);
            chk($sformatf("rnd%0d.win", g), WIN, exp_win);
            chk($sformatf("rnd%0d.lose", g), LOSE, exp_lose);
            chk($sformatf("rnd%0d.score", g), SCORE, exp_score % 16);
            chk($sformatf("rnd%0d.addr", g), SEQ_ADDR, exp_win ? len - 1 : exp_score);
            chk($sformatf("rnd%0d.busy", g), BUSY, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
